// File: rtl/obi_copy_engine.sv
`default_nettype none
// ============================================================================
// Module   : obi_copy_engine
// Purpose  : OBI initiator that copies a block of 32-bit words from a source
//            address to a destination address. Each word is one read followed
//            by one write, with at most one transaction outstanding.
// Ports    : clk_i, rst_i (async, active-high)
//            start_i, src_addr_i, dst_addr_i, len_words_i, abort_i  - control
//            busy_o, done_o, error_o, words_done_o                  - status
//            obi_req_o/gnt_i/addr_o/we_o/be_o/wdata_o/rvalid_i/rdata_i - bus
//            illegal_i - responder error flag, one cycle after a handshake
// Revision : 1.0 - initial release
// ============================================================================
module obi_copy_engine #(
    parameter int LEN_WIDTH = 16,
    parameter bit ERR_ABORT = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [31:0]          src_addr_i,
    input  logic [31:0]          dst_addr_i,
    input  logic [LEN_WIDTH-1:0] len_words_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [LEN_WIDTH-1:0] words_done_o,
    output logic                 obi_req_o,
    input  logic                 obi_gnt_i,
    output logic [31:0]          obi_addr_o,
    output logic                 obi_we_o,
    output logic [3:0]           obi_be_o,
    output logic [31:0]          obi_wdata_o,
    input  logic                 obi_rvalid_i,
    input  logic [31:0]          obi_rdata_i,
    input  logic                 illegal_i
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [29:0]            r_src_word;
    logic [29:0]            r_dst_word;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [LEN_WIDTH-1:0]   r_idx;
    logic [LEN_WIDTH-1:0]   r_words_done;
    logic [31:0]            r_data;
    logic                   r_err;
    logic                   r_abort;
    logic                   r_done;

    logic                   w_req;
    logic [29:0]            w_idx_ext;
    logic [LEN_WIDTH-1:0]   w_idx_inc;
    logic                   w_unused;

    // Byte-offset bits of the configured addresses are deliberately dropped.
    assign w_unused  = ^{src_addr_i[1:0], dst_addr_i[1:0]};
    assign w_idx_ext = 30'(r_idx);
    assign w_idx_inc = r_idx + LEN_WIDTH'(1);

    // ------------------------------------------------------------------------
    // Next-state logic and request generation
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_next = (len_words_i == '0) ? ST_DONE : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                // An illegal flag seen here belongs to the write just granted.
                // It can only arrive in the first RD_REQ cycle, so stopping
                // here never withdraws a request that was already visible.
                if (ERR_ABORT && illegal_i) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_req = 1'b1;
                    if (obi_gnt_i) begin
                        w_state_next = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (obi_rvalid_i) begin
                    w_state_next = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                w_req = 1'b1;
                if (obi_gnt_i) begin
                    if ((w_idx_inc == r_len) || r_abort || abort_i ||
                        (ERR_ABORT && r_err)) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_RD_REQ;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_src_word   <= '0;
            r_dst_word   <= '0;
            r_len        <= '0;
            r_idx        <= '0;
            r_words_done <= '0;
            r_data       <= '0;
            r_err        <= 1'b0;
            r_abort      <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == ST_DONE);
            if (r_state == ST_IDLE) begin
                if (start_i) begin
                    r_src_word   <= src_addr_i[31:2];
                    r_dst_word   <= dst_addr_i[31:2];
                    r_len        <= len_words_i;
                    r_idx        <= '0;
                    r_words_done <= '0;
                    r_err        <= 1'b0;
                    r_abort      <= 1'b0;
                end
            end else begin
                if (illegal_i) begin
                    r_err <= 1'b1;
                end
                if (abort_i) begin
                    r_abort <= 1'b1;
                end
                if ((r_state == ST_RD_WAIT) && obi_rvalid_i) begin
                    r_data <= obi_rdata_i;
                end
                if ((r_state == ST_WR_REQ) && obi_gnt_i) begin
                    r_idx        <= w_idx_inc;
                    r_words_done <= r_words_done + LEN_WIDTH'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs; address/data are forced to zero outside request states
    // ------------------------------------------------------------------------
    assign busy_o       = (r_state != ST_IDLE);
    assign done_o       = r_done;
    assign error_o      = r_err;
    assign words_done_o = r_words_done;
    assign obi_req_o    = w_req;
    assign obi_we_o     = (r_state == ST_WR_REQ);
    assign obi_be_o     = (r_state == ST_WR_REQ) ? 4'hF : 4'h0;
    assign obi_wdata_o  = (r_state == ST_WR_REQ) ? r_data : 32'h0;

    always_comb begin
        obi_addr_o = 32'h0;
        case (r_state)
            ST_RD_REQ: obi_addr_o = {r_src_word + w_idx_ext, 2'b00};
            ST_WR_REQ: obi_addr_o = {r_dst_word + w_idx_ext, 2'b00};
            default:   obi_addr_o = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_obi_copy_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_obi_copy_engine
// Purpose  : Self-checking bench for obi_copy_engine with a 16-word OBI memory
//            model (0x8000_0000..0x8000_003C legal, 0x9xxx_xxxx illegal).
// Revision : 1.0 - initial release
// ============================================================================
module tb_obi_copy_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len_words;
    logic        abort_sig;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_done;
    logic        obi_req;
    logic        obi_gnt;
    logic [31:0] obi_addr;
    logic        obi_we;
    logic [3:0]  obi_be;
    logic [31:0] obi_wdata;
    logic        obi_rvalid;
    logic [31:0] obi_rdata;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    obi_copy_engine #(
        .LEN_WIDTH (16),
        .ERR_ABORT (1'b1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .src_addr_i   (src_addr),
        .dst_addr_i   (dst_addr),
        .len_words_i  (len_words),
        .abort_i      (abort_sig),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .words_done_o (words_done),
        .obi_req_o    (obi_req),
        .obi_gnt_i    (obi_gnt),
        .obi_addr_o   (obi_addr),
        .obi_we_o     (obi_we),
        .obi_be_o     (obi_be),
        .obi_wdata_o  (obi_wdata),
        .obi_rvalid_i (obi_rvalid),
        .obi_rdata_i  (obi_rdata),
        .illegal_i    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- responder model ----------------
    logic [31:0] mem [16];
    int          stall = 0;
    int          wait_cnt = 0;
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = 4'd0;
    logic [31:0] pl_data = 32'h0;

    assign obi_gnt = obi_req && (wait_cnt >= stall);

    always @(posedge clk) begin
        obi_rvalid <= 1'b0;
        illegal    <= 1'b0;
        if (pl_en) mem[pl_idx] <= pl_data;
        if (obi_req) begin
            if (obi_gnt) begin
                wait_cnt <= 0;
                illegal  <= (obi_addr[31:28] != 4'h8);
                if (obi_we) begin
                    if (obi_addr[31:28] == 4'h8 && obi_be == 4'hF)
                        mem[obi_addr[5:2]] <= obi_wdata;
                end else begin
                    obi_rvalid <= 1'b1;
                    obi_rdata  <= (obi_addr[31:28] == 4'h8) ? mem[obi_addr[5:2]] : 32'hDEAD_BEEF;
                end
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [88:0] outs();
        return {obi_req, obi_we, obi_be, obi_addr, obi_wdata, busy, done, error, words_done};
    endfunction

    function automatic logic [69:0] bus_sig();
        return {obi_req, obi_we, obi_be, obi_addr, obi_wdata};
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // mem[i] = 0x11111111 * (i+1)
    task automatic load_pattern();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            pl_en   = 1'b1;
            pl_idx  = 4'(i);
            pl_data = 32'h1111_1111 * 32'(i + 1);
        end
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Start a copy, run until done_o, check bus stability while stalled.
    // cyc = clock edges after the edge that sampled start until done_o seen.
    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                       input int abort_at, output int cyc, output int reqs,
                       output logic [31:0] addr0, output logic err_done);
        logic [69:0] hold;
        logic        hold_v;
        logic        seen;
        @(negedge clk);
        src_addr = s; dst_addr = d; len_words = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; reqs = 0; addr0 = 32'h0; hold = '0; hold_v = 1'b0; seen = 1'b0;
        err_done = 1'b0;
        while (!done && cyc < 1000) begin
            if (hold_v && obi_req) chk("req_hold", 96'(bus_sig()), 96'(hold));
            if (obi_req) begin
                reqs++;
                chk("be_vs_we", 96'(obi_be), obi_we ? 96'hF : 96'h0);
                if (!seen) addr0 = obi_addr;
                seen = 1'b1;
            end
            hold_v    = obi_req && !obi_gnt;
            hold      = bus_sig();
            abort_sig = (cyc == abort_at);
            @(negedge clk);
            cyc++;
        end
        abort_sig = 1'b0;
        if (!done) chk("done_timeout", 96'(done), 96'h1);
        err_done = error;
        @(negedge clk);
        chk("done_single_pulse", 96'(done), 96'h0);
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        int          stall;
        int          exp_cyc;
        int          exp_req;
        logic [31:0] exp_addr0;
        int          first_idx;
        logic [31:0] exp_first;
        int          last_idx;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs [5];

    task automatic run_vec(input vec_t v, input int k);
        int          cyc;
        int          reqs;
        logic [31:0] a0;
        logic        ed;
        load_pattern();
        stall = v.stall;
        run(v.src, v.dst, v.len, -1, cyc, reqs, a0, ed);
        $display("vector %0d: cycles=%0d reqs=%0d", k, cyc, reqs);
        chk("vec_cycles",     96'(cyc),        96'(v.exp_cyc));
        chk("vec_req_cycles", 96'(reqs),       96'(v.exp_req));
        chk("vec_first_addr", 96'(a0),         96'(v.exp_addr0));
        chk("vec_words_done", 96'(words_done), 96'(v.len));
        chk("vec_error",      96'(ed),         96'h0);
        chk("vec_busy_after", 96'(busy),       96'h0);
        chk("vec_mem_first",  96'(mem[v.first_idx]), 96'(v.exp_first));
        chk("vec_mem_last",   96'(mem[v.last_idx]),  96'(v.exp_last));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          cyc;
        int          reqs;
        int          dones;
        logic [31:0] a0;
        logic        ed;

        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len_words = '0;
        abort_sig = 1'b0;

        //          src            dst            len stall cyc req addr0          fi first          li last
        vecs[0] = '{32'h8000_0000, 32'h8000_0008, 16'd2, 0,  7,  4, 32'h8000_0000,  2, 32'h1111_1111,  3, 32'h2222_2222};
        vecs[1] = '{32'h8000_0010, 32'h8000_0030, 16'd3, 3, 28, 24, 32'h8000_0010, 12, 32'h5555_5555, 14, 32'h7777_7777};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000, 16'd0, 0,  1,  0, 32'h0000_0000,  0, 32'h1111_1111,  0, 32'h1111_1111};
        vecs[3] = '{32'h8000_0003, 32'h8000_0022, 16'd1, 1,  6,  4, 32'h8000_0000,  8, 32'h1111_1111,  8, 32'h1111_1111};
        vecs[4] = '{32'h8000_0020, 32'h8000_0000, 16'd4, 0, 13,  8, 32'h8000_0020,  0, 32'h9999_9999,  3, 32'hCCCC_CCCC};

        repeat (3) @(negedge clk);
        chk("reset_outputs", 96'(outs()), 96'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", 96'(outs()), 96'h0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Illegal destination: first write flagged, copy stops after it.
        load_pattern();
        stall = 0;
        run(32'h8000_0000, 32'h9000_0000, 16'd3, -1, cyc, reqs, a0, ed);
        chk("illegal_cycles",     96'(cyc),        96'd5);
        chk("illegal_req_cycles", 96'(reqs),       96'd2);
        chk("illegal_words_done", 96'(words_done), 96'd1);
        chk("illegal_err_at_done", 96'(ed),        96'h1);
        chk("illegal_err_sticky", 96'(error),      96'h1);

        // Abort during RD_WAIT of word 1 of 4: word 1 still written.
        load_pattern();
        run(32'h8000_0000, 32'h8000_0020, 16'd4, 4, cyc, reqs, a0, ed);
        chk("abort_cycles",     96'(cyc),        96'd7);
        chk("abort_req_cycles", 96'(reqs),       96'd4);
        chk("abort_words_done", 96'(words_done), 96'd2);
        chk("abort_error",      96'(ed),         96'h0);
        chk("abort_mem8",       96'(mem[8]),     96'h1111_1111);
        chk("abort_mem9",       96'(mem[9]),     96'h2222_2222);
        chk("abort_mem10",      96'(mem[10]),    96'hBBBB_BBBB);

        // Reset while in WR_REQ of word 0.
        load_pattern();
        @(negedge clk);
        src_addr = 32'h8000_0000; dst_addr = 32'h8000_0030; len_words = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_wr_req", 96'({obi_req, obi_we}), 96'h3);
        rst = 1'b1;
        #1;
        chk("rst_outputs_now", 96'(outs()), 96'h0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("rst_no_done",   96'(dones),   96'h0);
        chk("rst_mem12",     96'(mem[12]), 96'hDDDD_DDDD);
        chk("rst_idle_outs", 96'(outs()),  96'h0);
        run_vec(vecs[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
